audio_serializer: RTL

AUDIO_SERIALIZER -- requirements
Module: audio_serializer

---
 rtl/audio_serializer.sv | 87 ++++++++
 1 files changed

// File: rtl/audio_serializer.sv
// Stereo 16-bit serializer: derives MCLK/SCK/LRCK from a 9-bit frame counter, I2S or left-justified.
// Optional mute input, enabled by defining AUDIO_SERIALIZER_MUTE_EN.
module audio_serializer #(
    parameter int LEFT_JUSTIFIED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] audio_left,
    input  logic [15:0] audio_right,
`ifdef AUDIO_SERIALIZER_MUTE_EN
    input  logic        mute,
`endif
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin,
    output logic        sample_req
);

    logic [8:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        mclk_q, mclk_d;
    logic        sck_q, sck_d;
    logic        lrck_q, lrck_d;
    logic        sdin_q, sdin_d;
    logic        req_q, req_d;
    logic        wrap;
    logic [4:0]  slot_d;
    logic [4:0]  bit_idx;

    always_comb begin
        cnt_d  = cnt_q + 9'd1;
        wrap   = (cnt_q == 9'd511);
        word_d = word_q;
        if (wrap) begin
`ifdef AUDIO_SERIALIZER_MUTE_EN
            word_d = mute ? 32'h0 : {audio_left, audio_right};
`else
            word_d = {audio_left, audio_right};
`endif
        end

        // Clock outputs track the counter value they will hold after this edge.
        mclk_d = cnt_d[1];
        sck_d  = cnt_d[3];
        lrck_d = cnt_d[8];
        req_d  = (cnt_d == 9'd0);

        // I2S index 32-s wraps to 0 at slot 0, which is handled separately.
        slot_d  = cnt_d[8:4];
        bit_idx = (LEFT_JUSTIFIED != 0) ? (5'd31 - slot_d) : (5'd0 - slot_d);
        sdin_d  = sdin_q;
        if (cnt_q[3:0] == 4'hF) begin
            if (LEFT_JUSTIFIED == 0 && slot_d == 5'd0)
                sdin_d = word_q[0];
            else
                sdin_d = word_d[bit_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 9'd0;
            word_q <= 32'h0;
            mclk_q <= 1'b0;
            sck_q  <= 1'b0;
            lrck_q <= 1'b0;
            sdin_q <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
            mclk_q <= mclk_d;
            sck_q  <= sck_d;
            lrck_q <= lrck_d;
            sdin_q <= sdin_d;
            req_q  <= req_d;
        end
    end

    assign audio_mclk = mclk_q;
    assign audio_sck  = sck_q;
    assign audio_lrck = lrck_q;
    assign audio_sdin = sdin_q;
    assign sample_req = req_q;

endmodule
